arb16_rr: RTL and testbench

ARB16_RR -- requirements
Module: arb16_rr

---
 rtl/arb16_rr_pkg.sv | 13 +
 rtl/arb16_rr_pick.sv | 30 +++
 rtl/arb16_rr.sv | 86 ++++++++
 tb/tb_arb16_rr.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/arb16_rr_pkg.sv
// arb16_rr_pkg: constants shared by the 16-way round-robin arbiter.
//   N_REQ   number of requesters
//   SEL_W   width of the mux select / owner index
//   HOLD_W  width of the hold counter
//   ST_*    FSM state encodings
package arb16_rr_pkg;
    localparam int N_REQ  = 16;
    localparam int SEL_W  = 4;
    localparam int HOLD_W = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
endpackage

// File: rtl/arb16_rr_pick.sv
// rr_pick16: combinational wrap-around priority search.
//   req   [15:0] in   request vector
//   ptr   [3:0]  in   starting index (highest priority)
//   found        out  any request set
//   idx   [3:0]  out  first set bit at or above ptr, wrapping 15->0
module rr_pick16
    import arb16_rr_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    logic [SEL_W-1:0] w_j;

    // Walk offsets from farthest to nearest so the nearest hit is the
    // last assignment and therefore wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        w_j   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j = ptr + SEL_W'(k);
            if (req[w_j]) begin
                found = 1'b1;
                idx   = w_j;
            end
        end
    end
endmodule

// File: rtl/arb16_rr.sv
// arb16_rr: 16-requester round-robin arbiter with a bounded hold time,
// driving the select of a shared 16:1 mux path.
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   req   [15:0]  in   per-requester request
//   gnt   [15:0]  out  one-hot grant (zero when no owner)
//   sel   [3:0]   out  owner index; holds last owner while idle
//   busy          out  a grant is active
//   forced        out  one-cycle pulse after a hold-timeout revocation
// MAX_HOLD (legal 1..255) bounds the consecutive cycles of one grant.
module arb16_rr
    import arb16_rr_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             forced
);
    logic [0:0]        r_state;
    logic [SEL_W-1:0]  r_owner;
    logic [SEL_W-1:0]  r_ptr;
    logic [HOLD_W-1:0] r_hold;
    logic              r_forced;

    logic              w_found;
    logic [SEL_W-1:0]  w_idx;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // The hold counter is loaded with 1 on grant so it equals the number
    // of grant cycles already served; at MAX_HOLD the grant is revoked.
    // Any release drops to IDLE for one cycle, giving the mux a dead cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_hold   <= '0;
            r_forced <= 1'b0;
        end else begin
            r_forced <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_BUSY;
                        r_owner <= w_idx;
                        r_hold  <= HOLD_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (!req[r_owner]) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_owner + SEL_W'(1);
                    end else if (r_hold >= HOLD_W'(MAX_HOLD)) begin
                        r_state  <= ST_IDLE;
                        r_ptr    <= r_owner + SEL_W'(1);
                        r_forced <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Grant is decoded from registered state only, never from live req.
    always_comb begin
        gnt = '0;
        if (r_state == ST_BUSY) gnt[r_owner] = 1'b1;
    end

    assign sel    = r_owner;
    assign busy   = (r_state == ST_BUSY);
    assign forced = r_forced;
endmodule

// File: tb/tb_arb16_rr.sv
module tb_arb16_rr;
    localparam int MAXH  = 8;
    localparam int BOUND = 16 * (MAXH + 1);

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] req = '0;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy, forced;

    int checks = 0;
    int failures = 0;

    arb16_rr #(.MAX_HOLD(MAXH)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .gnt(gnt), .sel(sel), .busy(busy), .forced(forced)
    );

    always #5 clk = ~clk;

    // Behavioural model: owner as an integer (-1 = none), grant age in cycles.
    int m_own = -1, m_ptr = 0, m_age = 0, m_last = 0;
    bit m_forced = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_own = -1; m_ptr = 0; m_age = 0; m_last = 0; m_forced = 0;
        end else begin
            m_forced = 0;
            if (m_own < 0) begin
                for (int k = 0; k < 16; k++) begin
                    if (m_own < 0 && req[(m_ptr + k) % 16]) begin
                        m_own = (m_ptr + k) % 16; m_age = 1; m_last = m_own;
                    end
                end
            end else if (!req[m_own]) begin
                m_ptr = (m_own + 1) % 16; m_own = -1;
            end else if (m_age >= MAXH) begin
                m_ptr = (m_own + 1) % 16; m_own = -1; m_forced = 1;
            end else begin
                m_age++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    bit chk_en = 0;
    bit saw7 = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_gnt", {16'h0, gnt}, (m_own < 0) ? 32'h0 : (32'h1 << m_own));
            chk("model_sel", {28'h0, sel}, m_last);
            chk("model_busy", {31'h0, busy}, (m_own >= 0) ? 32'h1 : 32'h0);
            chk("model_forced", {31'h0, forced}, {31'h0, m_forced});
        end
        if (gnt[7]) saw7 = 1;
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        tick(); reset_n = 1'b0; req = '0;
        tick(); reset_n = 1'b1;
    endtask

    task automatic wait_grant(input int exp, input int budget);
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            if (busy) ok = 1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL grant_timeout: no grant within %0d cycles, expected owner %0d", budget, exp);
        end else begin
            chk("grant_sel", {28'h0, sel}, exp);
            chk("grant_gnt", {16'h0, gnt}, 32'h1 << exp);
        end
    endtask

    // Called just after a grant is first observed; returns cycles the grant lasted.
    task automatic hold_len(input int exp, output int len);
        len = 1;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (busy && sel == 4'(exp)) len++;
            else break;
        end
    endtask

    initial begin
        int len;
        int wt [16];
        int max_wait;
        logic [31:0] r;

        do_reset();
        chk_en = 1;
        chk("reset_gnt", {16'h0, gnt}, 32'h0);
        chk("reset_sel", {28'h0, sel}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_forced", {31'h0, forced}, 32'h0);

        // Single requester held: 8-cycle grant then forced revocation.
        req = 16'h0001;
        tick();
        chk("r29_gnt", {16'h0, gnt}, 32'h1);
        chk("r29_sel", {28'h0, sel}, 32'h0);
        chk("r29_busy", {31'h0, busy}, 32'h1);
        repeat (7) tick();
        chk("r29_gnt_c8", {16'h0, gnt}, 32'h1);
        tick();
        chk("r29_gnt_rel", {16'h0, gnt}, 32'h0);
        chk("r29_forced", {31'h0, forced}, 32'h1);
        tick();
        chk("r29_forced_pulse", {31'h0, forced}, 32'h0);
        chk("r29_regrant", {16'h0, gnt}, 32'h1);

        // All requesting: rotation 0..15,0 with 8-cycle grants and one dead cycle.
        do_reset();
        req = 16'hFFFF;
        wait_grant(0, 2);
        for (int k = 0; k < 17; k++) begin
            hold_len(k % 16, len);
            chk("r30_len", len, MAXH);
            chk("r30_dead", {31'h0, busy}, 32'h0);
            chk("r30_forced", {31'h0, forced}, 32'h1);
            if (k < 16) wait_grant((k + 1) % 16, 1);
        end

        // Pointer wrap: 15 then 0 then 15.
        do_reset();
        req = 16'h8000;
        wait_grant(15, 3);
        req = 16'h8001;
        hold_len(15, len);
        chk("r31_len15", len, MAXH);
        wait_grant(0, 1);
        hold_len(0, len);
        wait_grant(15, 1);

        // Non-owner request during a grant is not latched.
        do_reset();
        req = 16'h0008;
        wait_grant(3, 3);
        saw7 = 0;
        tick(); req = 16'h0088;
        tick(); tick(); req = 16'h0008;
        tick(); req = 16'h0000;
        tick();
        chk("r32_dead_gnt", {16'h0, gnt}, 32'h0);
        chk("r32_dead_busy", {31'h0, busy}, 32'h0);
        repeat (3) tick();
        chk("r32_no7", {31'h0, saw7}, 32'h0);

        // Asynchronous reset mid-grant.
        do_reset();
        req = 16'h0020;
        wait_grant(5, 3);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("r33_gnt", {16'h0, gnt}, 32'h0);
        chk("r33_sel", {28'h0, sel}, 32'h0);
        chk("r33_busy", {31'h0, busy}, 32'h0);
        req = 16'h0021;
        tick(); reset_n = 1'b1;
        wait_grant(0, 2);

        // Random sticky request streams; liveness bound per requester.
        do_reset();
        max_wait = 0;
        for (int i = 0; i < 16; i++) wt[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 16; i++) begin
                if (req[i] && !gnt[i]) wt[i]++;
                else wt[i] = 0;
                if (wt[i] > max_wait) max_wait = wt[i];
            end
            r = $urandom;
            req = req | (r[15:0] & r[31:16] & 16'($urandom));
            if (busy && $urandom_range(0, 3) == 0) req = req & ~gnt;
            if ($urandom_range(0, 199) == 0) req = '0;
        end
        chk("liveness_ok", (max_wait <= BOUND) ? 32'h1 : 32'h0, 32'h1);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
